// File: rtl/imm_pack.sv
// Immediate encoder: range-checks a 32-bit immediate for an instruction format and
// scatters it into instr[31:7]. Two-stage valid/ready pipeline with a saturating error count.
module imm_pack #(
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [31:0]          imm_i,
  input  logic [2:0]           imm_sel_i,
  input  logic [24:0]          fields_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [24:0]          instr_o,
  output logic                 err_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  localparam logic [2:0] SEL_U    = 3'b000;
  localparam logic [2:0] SEL_J    = 3'b001;
  localparam logic [2:0] SEL_S    = 3'b010;
  localparam logic [2:0] SEL_B    = 3'b011;
  localparam logic [2:0] SEL_I    = 3'b100;
  localparam logic [2:0] SEL_ISH  = 3'b101;
  localparam logic [2:0] SEL_RSVD = 3'b110;
  localparam logic [2:0] SEL_IU   = 3'b111;

  logic                 r_s1_v;
  logic [31:0]          r_s1_imm;
  logic [2:0]           r_s1_sel;
  logic [24:0]          r_s1_fields;
  logic                 r_s1_err;
  logic                 r_s2_v;
  logic [24:0]          r_s2_instr;
  logic                 r_s2_err;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  logic        w_s2_adv;
  logic        w_s1_adv;
  logic        w_err;
  logic [24:0] w_pack;
  logic        w_cnt_inc;

  assign w_s2_adv = !r_s2_v || ready_i;
  assign w_s1_adv = !r_s1_v || w_s2_adv;
  assign ready_o  = w_s1_adv;

  assign valid_o   = r_s2_v;
  assign instr_o   = r_s2_instr;
  assign err_o     = r_s2_err;
  assign err_cnt_o = r_err_cnt;

  // Representability check on the incoming request (registered into stage 1)
  always_comb begin
    w_err = 1'b0;
    case (imm_sel_i)
      SEL_U:    w_err = |imm_i[11:0];
      SEL_J:    w_err = imm_i[0] || (imm_i[31:21] != {11{imm_i[20]}});
      SEL_S:    w_err = imm_i[31:12] != {20{imm_i[11]}};
      SEL_B:    w_err = imm_i[0] || (imm_i[31:13] != {19{imm_i[12]}});
      SEL_I:    w_err = imm_i[31:12] != {20{imm_i[11]}};
      SEL_ISH:  w_err = |imm_i[31:5];
      SEL_IU:   w_err = |imm_i[31:12];
      SEL_RSVD: w_err = 1'b1;
      default:  w_err = 1'b1;
    endcase
  end

  // Scatter the stage-1 immediate over the template; unowned bits pass through
  always_comb begin
    w_pack = r_s1_fields;
    case (r_s1_sel)
      SEL_U: w_pack[24:5] = r_s1_imm[31:12];
      SEL_J: begin
        w_pack[24]    = r_s1_imm[20];
        w_pack[23:14] = r_s1_imm[10:1];
        w_pack[13]    = r_s1_imm[11];
        w_pack[12:5]  = r_s1_imm[19:12];
      end
      SEL_S: begin
        w_pack[24:18] = r_s1_imm[11:5];
        w_pack[4:0]   = r_s1_imm[4:0];
      end
      SEL_B: begin
        w_pack[24]    = r_s1_imm[12];
        w_pack[23:18] = r_s1_imm[10:5];
        w_pack[4:1]   = r_s1_imm[4:1];
        w_pack[0]     = r_s1_imm[11];
      end
      SEL_I:    w_pack[24:13] = r_s1_imm[11:0];
      SEL_ISH:  w_pack[17:13] = r_s1_imm[4:0];
      SEL_IU:   w_pack[24:13] = r_s1_imm[11:0];
      SEL_RSVD: w_pack = r_s1_fields;
      default:  w_pack = r_s1_fields;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_s1_v      <= 1'b0;
      r_s1_imm    <= '0;
      r_s1_sel    <= '0;
      r_s1_fields <= '0;
      r_s1_err    <= 1'b0;
    end else begin
      if (flush_i)       r_s1_v <= 1'b0;
      else if (w_s1_adv) r_s1_v <= valid_i;
      if (w_s1_adv && valid_i) begin
        r_s1_imm    <= imm_i;
        r_s1_sel    <= imm_sel_i;
        r_s1_fields <= fields_i;
        r_s1_err    <= w_err;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_s2_v     <= 1'b0;
      r_s2_instr <= '0;
      r_s2_err   <= 1'b0;
    end else begin
      if (flush_i)       r_s2_v <= 1'b0;
      else if (w_s2_adv) r_s2_v <= r_s1_v;
      if (w_s2_adv && r_s1_v) begin
        r_s2_instr <= w_pack;
        r_s2_err   <= r_s1_err;
      end
    end
  end

  // Count erroneous output transfers; a transfer coinciding with a flush is not counted
  assign w_cnt_inc = r_s2_v && ready_i && r_s2_err && !flush_i && (r_err_cnt != '1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)          r_err_cnt <= '0;
    else if (w_cnt_inc) r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
  end

endmodule

// File: tb/tb_imm_pack.sv
// Directed bench for imm_pack: packing per format, error flags/count, stall, flush, reset.
module tb_imm_pack;

  localparam logic [2:0] SEL_U    = 3'b000;
  localparam logic [2:0] SEL_J    = 3'b001;
  localparam logic [2:0] SEL_S    = 3'b010;
  localparam logic [2:0] SEL_B    = 3'b011;
  localparam logic [2:0] SEL_I    = 3'b100;
  localparam logic [2:0] SEL_ISH  = 3'b101;
  localparam logic [2:0] SEL_RSVD = 3'b110;
  localparam logic [2:0] SEL_IU   = 3'b111;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] imm_i;
  logic [2:0]  imm_sel_i;
  logic [24:0] fields_i;
  logic        valid_o;
  logic        ready_i;
  logic [24:0] instr_o;
  logic        err_o;
  logic [7:0]  err_cnt_o;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;

  imm_pack #(.ERR_CNT_W(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .imm_i(imm_i), .imm_sel_i(imm_sel_i), .fields_i(fields_i), .valid_o(valid_o),
    .ready_i(ready_i), .instr_o(instr_o), .err_o(err_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference immediate generator (decode direction) for round-trip checks
  function automatic logic [31:0] imm_gen(input logic [24:0] w, input logic [2:0] sel);
    case (sel)
      SEL_U:   return {w[24:5], 12'b0};
      SEL_J:   return {{12{w[24]}}, w[12:5], w[13], w[23:14], 1'b0};
      SEL_S:   return {{20{w[24]}}, w[24:18], w[4:0]};
      SEL_B:   return {{20{w[24]}}, w[0], w[23:18], w[4:1], 1'b0};
      SEL_I:   return {{20{w[24]}}, w[24:13]};
      SEL_ISH: return {27'b0, w[17:13]};
      SEL_IU:  return {20'b0, w[24:13]};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic do_one(input string tag, input logic [31:0] imm, input logic [2:0] sel,
                        input logic [24:0] fld, input logic [24:0] exp_w, input logic exp_e);
    int n;
    @(negedge clk_i);
    valid_i = 1'b1; imm_i = imm; imm_sel_i = sel; fields_i = fld; ready_i = 1'b1;
    @(negedge clk_i);
    valid_i = 1'b0;
    n = 0;
    while (!valid_o && n < 10) begin
      @(negedge clk_i);
      n++;
    end
    check({tag, "_valid"}, 32'(valid_o), 32'd1);
    check({tag, "_latency"}, 32'(n), 32'd1);
    check({tag, "_instr"}, 32'(instr_o), 32'(exp_w));
    check({tag, "_err"}, 32'(err_o), 32'(exp_e));
    if (!exp_e) check({tag, "_roundtrip"}, imm_gen(instr_o, sel), imm);
    if (exp_e) exp_cnt++;
    @(negedge clk_i);
    check({tag, "_drained"}, 32'(valid_o), 32'd0);
    check({tag, "_cnt"}, 32'(err_cnt_o), 32'(exp_cnt));
  endtask

  initial begin
    int sent;
    int got;
    logic prev_stall;
    logic saw_ready_low;
    logic [24:0] prev_instr;

    rst_i = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    imm_i = '0; imm_sel_i = '0; fields_i = '0;
    #1;
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_instr", 32'(instr_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_cnt", 32'(err_cnt_o), 32'd0);
    check("rst_ready", 32'(ready_o), 32'd1);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;

    do_one("isgn_min",  32'hFFFF_F800, SEL_I,    25'h0,       25'h100_0000, 1'b0);
    do_one("b_ok",      32'h0000_0FFE, SEL_B,    25'h0,       25'h0FC_001F, 1'b0);
    do_one("j_range",   32'h0010_0000, SEL_J,    25'h0,       25'h100_0000, 1'b1);
    do_one("b_odd",     32'h0000_1001, SEL_B,    25'h0,       25'h100_0000, 1'b1);
    do_one("u_ok",      32'hABCD_E000, SEL_U,    25'h5,       25'h157_9BC5, 1'b0);
    do_one("u_low",     32'h1234_5001, SEL_U,    25'h0,       25'h024_68A0, 1'b1);
    do_one("s_neg",     32'hFFFF_FFF0, SEL_S,    25'h0,       25'h1FC_0010, 1'b0);
    do_one("s_pass",    32'hFFFF_FFF0, SEL_S,    25'h1FF_FFFF, 25'h1FF_FFF0, 1'b0);
    do_one("ish_max",   32'h0000_001F, SEL_ISH,  25'h0,       25'h003_E000, 1'b0);
    do_one("ish_range", 32'h0000_0020, SEL_ISH,  25'h0,       25'h000_0000, 1'b1);
    do_one("iu_max",    32'h0000_0FFF, SEL_IU,   25'h0,       25'h1FF_E000, 1'b0);
    do_one("iu_range",  32'h0000_1000, SEL_IU,   25'h0,       25'h000_0000, 1'b1);
    do_one("rsvd",      32'h0000_0000, SEL_RSVD, 25'h0AB_CDEF, 25'h0AB_CDEF, 1'b1);
    do_one("j_neg",     32'hFFFF_F002, SEL_J,    25'h0,       25'h100_5FE0, 1'b0);

    // Back-to-back with downstream stalled in cycles 3..7
    sent = 0; got = 0; prev_stall = 1'b0; saw_ready_low = 1'b0; prev_instr = '0;
    for (int k = 0; k < 40 && got < 8; k++) begin
      @(negedge clk_i);
      ready_i   = !(k >= 3 && k <= 7);
      valid_i   = (sent < 8);
      imm_i     = 32'(sent + 1) << 12;
      imm_sel_i = SEL_U;
      fields_i  = '0;
      #1;
      if (prev_stall) begin
        check("b2b_hold_valid", 32'(valid_o), 32'd1);
        check("b2b_hold_instr", 32'(instr_o), 32'(prev_instr));
      end
      if (!ready_o) begin
        saw_ready_low = 1'b1;
        check("b2b_ready_low", {30'b0, valid_o, ready_i}, 32'b10);
      end
      if (valid_o && ready_i) begin
        check("b2b_order", 32'(instr_o), 32'((got + 1) << 5));
        got++;
      end
      prev_stall = valid_o && !ready_i;
      prev_instr = instr_o;
      if (valid_i && ready_o) sent++;
    end
    valid_i = 1'b0; ready_i = 1'b1;
    check("b2b_sent", 32'(sent), 32'd8);
    check("b2b_got", 32'(got), 32'd8);
    check("b2b_backpressure", 32'(saw_ready_low), 32'd1);
    @(negedge clk_i);
    check("b2b_empty", 32'(valid_o), 32'd0);
    check("b2b_cnt", 32'(err_cnt_o), 32'(exp_cnt));

    // Flush with two erroneous requests in flight and downstream stalled
    @(negedge clk_i);
    valid_i = 1'b1; imm_sel_i = SEL_RSVD; fields_i = 25'h5; ready_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    flush_i = 1'b1;
    #1;
    check("flush_inflight", 32'(valid_o), 32'd1);
    @(negedge clk_i);
    flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    #1;
    check("flush_valid", 32'(valid_o), 32'd0);
    check("flush_cnt", 32'(err_cnt_o), 32'(exp_cnt));
    repeat (3) @(negedge clk_i);
    check("flush_stay_empty", 32'(valid_o), 32'd0);
    check("flush_cnt_after", 32'(err_cnt_o), 32'(exp_cnt));

    // Saturation: 300 reserved-sel transfers
    @(negedge clk_i);
    valid_i = 1'b1; imm_sel_i = SEL_RSVD; fields_i = '0; ready_i = 1'b1;
    repeat (300) @(negedge clk_i);
    valid_i = 1'b0;
    repeat (4) @(negedge clk_i);
    check("sat_cnt", 32'(err_cnt_o), 32'd255);

    // Async reset in the middle of a stream
    valid_i = 1'b1; imm_sel_i = SEL_RSVD; fields_i = 25'h1AB_CDEF;
    repeat (3) @(negedge clk_i);
    #1;
    check("mid_valid_before", 32'(valid_o), 32'd1);
    check("mid_instr_before", 32'(instr_o), 32'h1AB_CDEF);
    #1;
    rst_i = 1'b1; valid_i = 1'b0;
    #1;
    check("mid_rst_valid", 32'(valid_o), 32'd0);
    check("mid_rst_instr", 32'(instr_o), 32'd0);
    check("mid_rst_err", 32'(err_o), 32'd0);
    check("mid_rst_cnt", 32'(err_cnt_o), 32'd0);
    check("mid_rst_ready", 32'(ready_o), 32'd1);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("post_rst_valid", 32'(valid_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
